// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: one bit period per rising edge of BaudOut.
// Sends start bit, LSB-first data, optional parity and stop bit(s) on TxOut.

// state  | meaning
// IDLE   | line high, BaudRate follows BaudRateReq, waiting for Send
// SYNC   | frame accepted, waiting for the first tick to drop the line
// START  | start bit on the line
// DATA   | data bits on the line, LSB first
// PARITY | parity bit on the line
// STOP   | stop bit(s) on the line
module uart_tx_frame_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    input  logic                 BaudOut,
    input  logic [1:0]           BaudRateReq,
    input  logic [DATA_BITS-1:0] DataIn,
    input  logic                 Send,
    input  logic [1:0]           ParityType,
    output logic [1:0]           BaudRate,
    output logic                 TxOut,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Done
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_nxt;
    logic                 baud_prev;
    logic                 tick;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic                 stop_cnt, stop_cnt_nxt;
    logic                 par_en, par_en_nxt;
    logic                 par_bit, par_bit_nxt;
    logic                 tx_nxt;
    logic                 ready_nxt;
    logic                 done_nxt;
    logic [1:0]           rate_nxt;

    assign tick = BaudOut & ~baud_prev;
    assign Busy = (state != S_IDLE);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state     <= S_IDLE;
            baud_prev <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
            TxOut     <= 1'b1;
            Ready     <= 1'b1;
            Done      <= 1'b0;
            BaudRate  <= 2'b10;
        end else begin
            state     <= state_nxt;
            baud_prev <= BaudOut;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            stop_cnt  <= stop_cnt_nxt;
            par_en    <= par_en_nxt;
            par_bit   <= par_bit_nxt;
            TxOut     <= tx_nxt;
            Ready     <= ready_nxt;
            Done      <= done_nxt;
            BaudRate  <= rate_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_reg;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        par_en_nxt   = par_en;
        par_bit_nxt  = par_bit;
        tx_nxt       = TxOut;
        ready_nxt    = Ready;
        done_nxt     = 1'b0;
        rate_nxt     = BaudRate;

        case (state)
            S_IDLE: begin
                tx_nxt   = 1'b1;
                rate_nxt = BaudRateReq;
                // A tick coinciding with accept is dropped: SYNC waits for the next one.
                if (Send && Ready) begin
                    shift_nxt   = DataIn;
                    par_en_nxt  = (ParityType == 2'b01) || (ParityType == 2'b10);
                    par_bit_nxt = (ParityType == 2'b10) ? ^DataIn : ~^DataIn;
                    ready_nxt   = 1'b0;
                    state_nxt   = S_SYNC;
                end
            end
            S_SYNC: begin
                if (tick) begin
                    tx_nxt    = 1'b0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_nxt      = shift_reg[0];
                    bit_cnt_nxt = '0;
                    state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt != LAST_BIT) begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        shift_nxt   = shift_reg >> 1;
                        tx_nxt      = shift_reg[1];
                    end else if (par_en) begin
                        tx_nxt    = par_bit;
                        state_nxt = S_PARITY;
                    end else begin
                        tx_nxt       = 1'b1;
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    tx_nxt       = 1'b1;
                    stop_cnt_nxt = 1'b0;
                    state_nxt    = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_cnt != LAST_STOP) begin
                        stop_cnt_nxt = stop_cnt + 1'b1;
                    end else begin
                        done_nxt  = 1'b1;
                        ready_nxt = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: table vectors, hand-written corner sequences and
// random frames, each line bit compared against a frame built from the UART rules.
module tb_uart_tx_frame_ctrl;

    logic       Clk;
    logic       ResetN;
    logic       BaudOut;
    logic       send;
    logic [7:0] data_in;
    logic [1:0] parity_type;
    logic [1:0] baud_rate_req;
    logic       sel;

    logic [1:0] rate1, rate2;
    logic       tx1, tx2, ready1, ready2, busy1, busy2, done1, done2;
    logic       send1, send2;
    logic [1:0] rate_m;
    logic       tx_m, ready_m, busy_m, done_m;

    // sel picks which device (1 or 2 stop bits) the tasks drive and observe
    assign send1   = send & ~sel;
    assign send2   = send & sel;
    assign rate_m  = sel ? rate2  : rate1;
    assign tx_m    = sel ? tx2    : tx1;
    assign ready_m = sel ? ready2 : ready1;
    assign busy_m  = sel ? busy2  : busy1;
    assign done_m  = sel ? done2  : done1;

    uart_tx_frame_ctrl #(.DATA_BITS(8), .STOP_BITS(1)) dut (
        .Clk(Clk), .ResetN(ResetN), .BaudOut(BaudOut), .BaudRateReq(baud_rate_req),
        .DataIn(data_in), .Send(send1), .ParityType(parity_type), .BaudRate(rate1),
        .TxOut(tx1), .Ready(ready1), .Busy(busy1), .Done(done1)
    );

    uart_tx_frame_ctrl #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .Clk(Clk), .ResetN(ResetN), .BaudOut(BaudOut), .BaudRateReq(baud_rate_req),
        .DataIn(data_in), .Send(send2), .ParityType(parity_type), .BaudRate(rate2),
        .TxOut(tx2), .Ready(ready2), .Busy(busy2), .Done(done2)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] pt;
        logic [1:0] req;
        logic [1:0] mid;
        bit         par_en;
        bit         par;
    } vec_t;

    vec_t vecs[12];

    int         n_vec = 0;
    int         n_err = 0;
    int         half = 3;
    int         rise_cnt = 0;
    int         done_cnt = 0;
    logic       baud_q = 1'b0;
    int         ref_cnt;
    int         done_base;
    int         len1;
    logic [1:0] frozen_rate;
    logic [1:0] mid_req;
    bit         exp_q[$];
    logic [7:0] rd;
    logic [1:0] rpt, rreq, rmid;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        BaudOut = 1'b0;
        forever begin
            repeat (half) @(posedge Clk);
            #1 BaudOut = ~BaudOut;
        end
    end

    // rising edges of BaudOut and Done pulses, sampled just after each clock edge
    initial begin
        forever begin
            @(posedge Clk);
            #2;
            if (BaudOut && !baud_q) rise_cnt++;
            baud_q = BaudOut;
            if (done_m) done_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic wait_rise(input int target);
        for (int k = 0; k < 4000 && rise_cnt < target; k++) @(negedge Clk);
        if (rise_cnt < target) begin
            n_vec++;
            n_err++;
            $display("FAIL baud_wait: got %0d rises, expected %0d", rise_cnt, target);
        end
    endtask

    // Reference frame: start 0, data LSB first, parity making the one-count odd/even, stop 1s
    task automatic build_ref(input logic [7:0] d, input logic [1:0] pt, input int nstop);
        int ones = $countones(d);
        exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++) exp_q.push_back(d[b]);
        if (pt == 2'b01) exp_q.push_back((ones % 2) == 0);
        else if (pt == 2'b10) exp_q.push_back((ones % 2) == 1);
        for (int s = 0; s < nstop; s++) exp_q.push_back(1'b1);
    endtask

    task automatic start_frame(input logic [7:0] d, input logic [1:0] pt,
                               input logic [1:0] req, input bit hold);
        int k = 0;
        while (!ready_m && k < 4000) begin
            @(negedge Clk);
            k++;
        end
        chk("ready_before_send", 0, int'(ready_m), 1);
        data_in       = d;
        parity_type   = pt;
        baud_rate_req = req;
        frozen_rate   = req;
        send          = 1'b1;
        ref_cnt       = rise_cnt;
        done_base     = done_cnt;
        if (!hold) begin
            @(negedge Clk);
            send = 1'b0;
        end
    endtask

    task automatic check_stream(input int n, input int chg_idx, input logic [7:0] chg_data,
                                input bit pulse, input int drop_idx);
        for (int i = 0; i < n; i++) begin
            wait_rise(ref_cnt + 1 + i);
            @(negedge Clk);
            @(negedge Clk);
            chk("tx_bit", i, int'(tx_m), int'(exp_q[i]));
            chk("rate_frozen", i, int'(rate_m), int'(frozen_rate));
            if (i == 0) begin
                chk("busy_in_frame", i, int'(busy_m), 1);
                chk("ready_in_frame", i, int'(ready_m), 0);
            end
            if (i == 1) baud_rate_req = mid_req;
            if (i == drop_idx) send = 1'b0;
            if (i == chg_idx) begin
                data_in = chg_data;
                if (pulse) begin
                    send = 1'b1;
                    @(negedge Clk);
                    send = 1'b0;
                end
            end
        end
    endtask

    task automatic end_check(input int n, input int done_exp);
        chk("done_early", n, done_cnt - done_base, done_exp - 1);
        wait_rise(ref_cnt + n + 1);
        @(negedge Clk);
        @(negedge Clk);
        chk("done_count", n, done_cnt - done_base, done_exp);
        chk("done_width", n, int'(done_m), 0);
        chk("ready_after", n, int'(ready_m), 1);
        chk("busy_after", n, int'(busy_m), 0);
        chk("tx_idle", n, int'(tx_m), 1);
        chk("rate_idle", n, int'(rate_m), int'(baud_rate_req));
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [1:0] pt,
                             input logic [1:0] req, input logic [1:0] mid);
        mid_req = mid;
        start_frame(d, pt, req, 1'b0);
        check_stream(exp_q.size(), -1, 8'h00, 1'b0, -1);
        end_check(exp_q.size(), 1);
    endtask

    initial begin
        ResetN        = 1'b0;
        send          = 1'b0;
        data_in       = 8'h00;
        parity_type   = 2'b00;
        baud_rate_req = 2'b01;
        sel           = 1'b0;
        vecs = '{
            '{8'hA5, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0},
            '{8'h55, 2'b01, 2'b01, 2'b11, 1'b1, 1'b1},
            '{8'h0F, 2'b01, 2'b11, 2'b10, 1'b1, 1'b1},
            '{8'h00, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1},
            '{8'h00, 2'b10, 2'b11, 2'b00, 1'b1, 1'b0},
            '{8'h01, 2'b10, 2'b10, 2'b11, 1'b1, 1'b1},
            '{8'h01, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0},
            '{8'hFF, 2'b00, 2'b10, 2'b01, 1'b0, 1'b0},
            '{8'h80, 2'b11, 2'b00, 2'b10, 1'b0, 1'b0},
            '{8'h3C, 2'b10, 2'b11, 2'b01, 1'b1, 1'b0},
            '{8'h7F, 2'b01, 2'b10, 2'b00, 1'b1, 1'b0},
            '{8'h7F, 2'b10, 2'b01, 2'b11, 1'b1, 1'b1}
        };

        repeat (3) @(negedge Clk);
        chk("rst_tx", 0, int'(tx1), 1);
        chk("rst_ready", 0, int'(ready1), 1);
        chk("rst_busy", 0, int'(busy1), 0);
        chk("rst_done", 0, int'(done1), 0);
        chk("rst_rate", 0, int'(rate1), 2);
        chk("rst_tx2", 0, int'(tx2), 1);
        chk("rst_rate2", 0, int'(rate2), 2);
        ResetN = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rate_track", 0, int'(rate1), 1);

        for (int v = 0; v < 12; v++) begin
            exp_q.delete();
            exp_q.push_back(1'b0);
            for (int b = 0; b < 8; b++) exp_q.push_back(vecs[v].data[b]);
            if (vecs[v].par_en) exp_q.push_back(vecs[v].par);
            exp_q.push_back(1'b1);
            run_frame(vecs[v].data, vecs[v].pt, vecs[v].req, vecs[v].mid);
        end

        // Send pulse with new data while busy must not start or alter a frame
        exp_q.delete();
        build_ref(8'hC3, 2'b01, 1);
        mid_req = 2'b10;
        start_frame(8'hC3, 2'b01, 2'b10, 1'b0);
        check_stream(exp_q.size(), 3, 8'h3C, 1'b1, -1);
        end_check(exp_q.size(), 1);
        wait_rise(ref_cnt + exp_q.size() + 3);
        @(negedge Clk);
        chk("ignored_busy", 0, int'(busy_m), 0);
        chk("ignored_tx", 0, int'(tx_m), 1);
        chk("ignored_done", 0, done_cnt - done_base, 1);

        // Reset during data bit 3 of an all-zero byte
        exp_q.delete();
        build_ref(8'h00, 2'b10, 1);
        mid_req = 2'b00;
        start_frame(8'h00, 2'b10, 2'b00, 1'b0);
        check_stream(5, -1, 8'h00, 1'b0, -1);
        baud_rate_req = 2'b11;
        ResetN = 1'b0;
        #1;
        chk("midrst_tx", 0, int'(tx_m), 1);
        chk("midrst_ready", 0, int'(ready_m), 1);
        chk("midrst_busy", 0, int'(busy_m), 0);
        chk("midrst_done", 0, int'(done_m), 0);
        chk("midrst_rate", 0, int'(rate_m), 2);
        @(negedge Clk);
        ResetN = 1'b1;
        repeat (3) @(negedge Clk);
        exp_q.delete();
        build_ref(8'hA5, 2'b01, 1);
        run_frame(8'hA5, 2'b01, 2'b01, 2'b11);

        // Two stop bits
        sel = 1'b1;
        @(negedge Clk);
        exp_q.delete();
        build_ref(8'hFF, 2'b00, 2);
        run_frame(8'hFF, 2'b00, 2'b10, 2'b01);
        exp_q.delete();
        build_ref(8'h12, 2'b10, 2);
        run_frame(8'h12, 2'b10, 2'b00, 2'b11);
        sel = 1'b0;
        @(negedge Clk);

        // Send held across two frames: one idle bit time, then the second start bit
        exp_q.delete();
        build_ref(8'h55, 2'b01, 1);
        len1 = exp_q.size();
        exp_q.push_back(1'b1);
        build_ref(8'h0F, 2'b01, 1);
        mid_req = 2'b11;
        start_frame(8'h55, 2'b01, 2'b11, 1'b1);
        check_stream(exp_q.size(), 0, 8'h0F, 1'b0, len1 + 1);
        end_check(exp_q.size(), 2);

        for (int r = 0; r < 30; r++) begin
            sel  = 1'($urandom_range(0, 1));
            half = int'($urandom_range(2, 5));
            repeat ($urandom_range(0, 15)) @(negedge Clk);
            rd   = 8'($urandom);
            rpt  = 2'($urandom_range(0, 3));
            rreq = 2'($urandom_range(0, 3));
            rmid = 2'($urandom_range(0, 3));
            exp_q.delete();
            build_ref(rd, rpt, sel ? 2 : 1);
            run_frame(rd, rpt, rreq, rmid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
